dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sub-word store sequencer in front of the single-port word-wide data memory (1-cycle read latency, word write only). It shares the memory between the core load/store unit (requester 0) and the debug/loader port (requester 1) using round-robin arbitration. Byte-enabled stores become a read-modify-write sequence. Address and alignment faults are flagged without touching memory.

## Interface
- `MEMORY_SIZE`, 8192: memory size in bytes (power of two). Any byte address ≥ `MEMORY_SIZE` is out of range.
- `clk` in 1: the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in [1:0]: request valid, one bit per requester.
- `req_ready` out [1:0]: request accepted this cycle when `req_valid[i] & req_ready[i]`.
- `req_we` in [1:0]: 1 = store, 0 = load.
- `req_addr` in [1:0][31:0]: byte address.
- `req_wdata` in [1:0][31:0]: store data.
- `req_be` in [1:0][3:0]: store byte enables. Ignored for loads.
- `rsp_valid` out [1:0]: one-cycle response pulse. Requesters cannot stall it.
- `rsp_rdata` out [31:0]: load data. Shared bus, qualified by `rsp_valid`.
- `rsp_err` out 1: fault flag for the pulsing response.
- `mem_en` out 1: memory enable.
- `mem_we` out 1: memory write enable.
- `mem_addr` out [31:0]: word-aligned byte address to memory.
- `mem_din` out [31:0]: memory write data.
- `mem_dout` in [31:0]: memory read data, valid the cycle after an enabled read.

## Operation
- States:
  - IDLE: accept a request.
  - RD_RSP: load data returning. A new request may be accepted in the same cycle.
  - RMW_WR: merge and write. No request is accepted.
- Arbitration:
  - Only one grant per cycle.
  - If only one requester is valid, it wins.
  - If both are valid, the requester not granted last wins. The pointer updates only on acceptance.
- `req_ready[i]` = grant to i, `rst_n` high, and state ≠ RMW_WR. It is combinational from `req_valid` and state.
- A fault is `addr ≥ MEMORY_SIZE` or `addr[1:0] ≠ 0`. A faulting request:
  - does not drive `mem_en`;
  - gets a response next cycle with `rsp_err`=1 and `rsp_rdata`=0.
- Load: `mem_en`=1 and `mem_we`=0 in the accept cycle. The response carries `mem_dout`.
- Full store (`be`=4'hF): `mem_en`=`mem_we`=1 with `mem_din`=wdata in the accept cycle. Ack next cycle.
- Empty store (`be`=0): no memory access. Ack next cycle, `rsp_err`=0.
- Partial store:
  - Accept cycle: read the word. Latch wdata, be, addr and requester id.
  - RMW_WR cycle: write byte k = be[k] ? wdata byte k : `mem_dout` byte k, then ack.
- `rsp_rdata` = `mem_dout` only for a non-faulting load response, otherwise 0.
- `rsp_err` is 0 whenever no `rsp_valid` bit is set.

## Timing
- Accept in cycle T. Load, full store, empty store and faults all respond at T+1. Partial stores respond at T+2.
- Throughput:
  - Loads and full stores: one per cycle, back-to-back.
  - Partial stores: one per 2 cycles, since `req_ready` is 0 in RMW_WR.
- Store at T followed by a load of the same word at T+1 returns the new data, because the memory write completes at the T edge.
- A load accepted in the RMW_WR-exit cycle observes the merged word.
- Reset values:
  - `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0.
  - State is IDLE and the round-robin pointer favours requester 0.
- Reset asserted mid-RMW drops the pending write and its response. Memory contents are untouched by reset.
- Responses never collide: at most one request is in flight per cycle, and the responding requester is known from the latched id.

## Structure
- Package `dmem_arbiter_pkg` holds:
  - the state enum;
  - requester index constants `REQ_CORE`=0 and `REQ_DBG`=1;
  - a `merge_be(old, new, be)` function;
  - a `is_fault(addr)` function parameterised on size.
- Sub-module `rr_arbiter2`: two-input round-robin arbiter. Inputs are request, grant-accepted and reset. The output is a one-hot grant. The pointer is a flop.
- Top level: FSM, response pipeline register (valid, id, is_load, err), RMW latch.

## Test plan
- Core loads 0x10 while debug is idle → `mem_en`=1 and `mem_addr`=0x10 at T. `rsp_valid`=2'b01 at T+1 with the memory word.
- Both requesters hold valid loads for 4 cycles → grants alternate 0,1,0,1 (starting at 0 after reset). Each response arrives at T+1 on the correct bit.
- Word 0x20 = 0xAABBCCDD; store wdata 0x11223344, be 4'b0101 → write at T+1 of 0xAA22CC44. Ack at T+2. `req_ready`=0 at T+1. A reload returns 0xAA22CC44.
- Load 0x2002 and load 0x2000 with `MEMORY_SIZE`=8192 → no `mem_en`. `rsp_err`=1 and `rsp_rdata`=0 at T+1 for each.
- Full store 0xDEADBEEF to 0x40 at T, load 0x40 at T+1 → 0xDEADBEEF at T+2. A be=0 store acks at T+1 with `mem_en`=0.
- Assert `rst_n`=0 during RMW_WR → no write, no `rsp_valid`. All outputs read 0 immediately. Memory word is unchanged.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter: FSM states,
// requester indices, byte-lane merge and address fault detection.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_RSP,
    ST_RMW_WR
  } state_e;

  localparam int unsigned REQ_CORE = 0;
  localparam int unsigned REQ_DBG  = 1;

  function automatic logic [31:0] merge_be(
    input logic [31:0] old_word,
    input logic [31:0] new_word,
    input logic [3:0]  be
  );
    logic [31:0] res;
    res = old_word;
    for (int unsigned k = 0; k < 4; k++) begin
      if (be[k]) res[8*k +: 8] = new_word[8*k +: 8];
    end
    return res;
  endfunction

  function automatic logic is_fault(
    input logic [31:0] addr,
    input logic [31:0] size
  );
    return (addr >= size) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-input round-robin arbiter; the priority pointer moves only when
// the issued grant is actually accepted.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt_o = '0;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
      default: gnt_o = '0;
    endcase
  end

  // Accepting requester 0 hands priority to requester 1, and vice versa.
  assign prio_d = accept_i ? gnt_o[0] : prio_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port word memory between core and debug requesters;
// sub-word stores are sequenced as read-modify-write.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MEMORY_SIZE = 8192
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req_we,
  input  logic [1:0][31:0] req_addr,
  input  logic [1:0][31:0] req_wdata,
  input  logic [1:0][3:0] req_be,
  output logic [1:0]      rsp_valid,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_err,
  output logic            mem_en,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_din,
  input  logic [31:0]     mem_dout
);

  state_e      state_q, state_d;
  logic [1:0]  gnt;
  logic        accept;
  logic        sel;
  logic        a_we;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic [3:0]  a_be;
  logic        a_fault;

  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_load_q, rsp_load_d;

  logic [31:0] rmw_addr_q, rmw_addr_d;
  logic [31:0] rmw_wdata_q, rmw_wdata_d;
  logic [3:0]  rmw_be_q, rmw_be_d;
  logic        rmw_id_q, rmw_id_d;

  rr_arbiter2 u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req_valid),
    .accept_i (accept),
    .gnt_o    (gnt)
  );

  assign req_ready = gnt & {2{rst_n && (state_q != ST_RMW_WR)}};
  assign accept    = |(req_valid & req_ready);

  assign sel     = gnt[REQ_DBG];
  assign a_we    = req_we[sel];
  assign a_addr  = req_addr[sel];
  assign a_wdata = req_wdata[sel];
  assign a_be    = req_be[sel];
  assign a_fault = is_fault(a_addr, 32'(MEMORY_SIZE));

  always_comb begin
    state_d     = state_q;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_din     = '0;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    rsp_load_d  = 1'b0;
    rmw_addr_d  = rmw_addr_q;
    rmw_wdata_d = rmw_wdata_q;
    rmw_be_d    = rmw_be_q;
    rmw_id_d    = rmw_id_q;

    unique case (state_q)
      ST_RMW_WR: begin
        // mem_dout holds the word read in the accept cycle.
        mem_en               = 1'b1;
        mem_we               = 1'b1;
        mem_addr             = rmw_addr_q;
        mem_din              = merge_be(mem_dout, rmw_wdata_q, rmw_be_q);
        rsp_valid_d[rmw_id_q] = 1'b1;
        state_d              = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          rsp_valid_d = gnt;
          if (a_fault) begin
            rsp_err_d = 1'b1;
          end else if (!a_we) begin
            mem_en     = 1'b1;
            mem_addr   = {a_addr[31:2], 2'b00};
            rsp_load_d = 1'b1;
            state_d    = ST_RD_RSP;
          end else if (a_be == 4'hF) begin
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = {a_addr[31:2], 2'b00};
            mem_din  = a_wdata;
          end else if (a_be != 4'h0) begin
            mem_en      = 1'b1;
            mem_addr    = {a_addr[31:2], 2'b00};
            rmw_addr_d  = {a_addr[31:2], 2'b00};
            rmw_wdata_d = a_wdata;
            rmw_be_d    = a_be;
            rmw_id_d    = sel;
            rsp_valid_d = '0;
            state_d     = ST_RMW_WR;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
      rmw_addr_q  <= '0;
      rmw_wdata_q <= '0;
      rmw_be_q    <= '0;
      rmw_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_load_q  <= rsp_load_d;
      rmw_addr_q  <= rmw_addr_d;
      rmw_wdata_q <= rmw_wdata_d;
      rmw_be_q    <= rmw_be_d;
      rmw_id_q    <= rmw_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = (|rsp_valid_q && rsp_load_q) ? mem_dout : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural memory plus a transaction-level
// reference (serial memory image, round-robin rule, response schedule).
module tb_dmem_arbiter;

  localparam int unsigned MSIZE = 8192;
  localparam int unsigned WORDS = MSIZE / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_we;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0][3:0]  req_be;
  logic [1:0]       rsp_valid;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic             mem_en;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_din;
  logic [31:0]      mem_dout;

  dmem_arbiter #(.MEMORY_SIZE(MSIZE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:WORDS-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[12:2]] <= mem_din;
      else        mem_dout <= mem[mem_addr[12:2]];
    end
  end

  typedef struct {
    int          due;
    int          who;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic [31:0] ref_mem [0:WORDS-1];
  rsp_t        pend_q[$];
  bit          prio;
  bit          busy;
  bit          wr_pend;
  int          wr_idx;
  logic [31:0] wr_word;
  int          cyc;
  int          total;
  int          bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic push_rsp(input int due, input int who, input logic [31:0] data, input logic err);
    rsp_t r;
    r.due = due; r.who = who; r.data = data; r.err = err;
    pend_q.push_back(r);
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    req_valid[i] = v;
    req_we[i]    = we;
    req_addr[i]  = a;
    req_wdata[i] = d;
    req_be[i]    = be;
  endtask

  task automatic clear_reqs();
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
  endtask

  // One clock cycle: check outputs mid-cycle against the reference, then
  // let the edge happen and commit the reference state.
  task automatic tick();
    logic [1:0]  exp_v;
    logic [31:0] exp_d;
    logic        exp_e;
    logic [1:0]  g;
    int          w;
    logic [31:0] a;
    logic [31:0] merged;
    bit          next_busy;
    rsp_t        r;
    @(negedge clk);
    exp_v = '0; exp_d = '0; exp_e = 1'b0;
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      r = pend_q.pop_front();
      exp_v[r.who] = 1'b1;
      exp_d = r.data;
      exp_e = r.err;
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    chk("rsp_rdata", rsp_rdata, exp_d);
    chk("rsp_err", 32'(rsp_err), 32'(exp_e));

    g = '0;
    if (!busy) begin
      if (req_valid == 2'b11) g = prio ? 2'b10 : 2'b01;
      else                    g = req_valid;
    end
    chk("req_ready", 32'(req_ready), 32'(g));

    next_busy = 1'b0;
    if (g != 2'b00) begin
      w = g[1] ? 1 : 0;
      a = req_addr[w];
      prio = (w == 0);
      if (a >= MSIZE || a[1:0] != 2'b00) begin
        chk("fault_mem_en", 32'(mem_en), 32'd0);
        push_rsp(cyc + 1, w, 32'h0, 1'b1);
      end else if (!req_we[w]) begin
        chk("ld_mem_en", 32'(mem_en), 32'd1);
        chk("ld_mem_we", 32'(mem_we), 32'd0);
        chk("ld_mem_addr", mem_addr, a);
        push_rsp(cyc + 1, w, ref_mem[a / 4], 1'b0);
      end else if (req_be[w] == 4'hF) begin
        chk("st_mem_we", 32'(mem_en & mem_we), 32'd1);
        chk("st_mem_din", mem_din, req_wdata[w]);
        ref_mem[a / 4] = req_wdata[w];
        push_rsp(cyc + 1, w, 32'h0, 1'b0);
      end else if (req_be[w] == 4'h0) begin
        chk("nop_mem_en", 32'(mem_en), 32'd0);
        push_rsp(cyc + 1, w, 32'h0, 1'b0);
      end else begin
        chk("rmw_rd", 32'({mem_en, mem_we}), 32'b10);
        merged = ref_mem[a / 4];
        for (int k = 0; k < 4; k++)
          if (req_be[w][k]) merged[8*k +: 8] = req_wdata[w][8*k +: 8];
        wr_pend = 1'b1;
        wr_idx  = int'(a / 4);
        wr_word = merged;
        push_rsp(cyc + 2, w, 32'h0, 1'b0);
        next_busy = 1'b1;
      end
    end
    if (busy && wr_pend) begin
      chk("rmw_wr", 32'({mem_en, mem_we}), 32'b11);
      chk("rmw_din", mem_din, wr_word);
    end

    @(posedge clk);
    #1;
    if (busy && wr_pend) begin
      ref_mem[wr_idx] = wr_word;
      wr_pend = 1'b0;
    end
    busy = next_busy;
    cyc++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp"}, 32'({rsp_valid, rsp_err}), 32'd0);
    chk({tag, "_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_mem"}, 32'({mem_en, mem_we}), 32'd0);
    chk({tag, "_maddr"}, mem_addr, 32'd0);
    chk({tag, "_mdin"}, mem_din, 32'd0);
  endtask

  initial begin
    logic [31:0] orig;
    logic [31:0] ra;
    logic [3:0]  rbe;
    total = 0; bad = 0; cyc = 0;
    prio = 1'b0; busy = 1'b0; wr_pend = 1'b0;
    mem_dout = '0;
    clear_reqs();
    for (int i = 0; i < int'(WORDS); i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[8] = 32'hAABBCCDD; ref_mem[8] = 32'hAABBCCDD;

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    // Both requesters hold loads: grants alternate starting at core.
    set_req(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    repeat (4) tick();
    clear_reqs();
    tick();

    // Core load while debug idle.
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    tick();
    clear_reqs();
    tick();

    // Partial store from debug; core load of the same word waits out RMW_WR.
    set_req(1, 1'b1, 1'b1, 32'h20, 32'h11223344, 4'b0101);
    tick();
    clear_reqs();
    set_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    tick();
    tick();
    clear_reqs();
    tick();
    chk("rmw_word", mem[8], 32'hAA22CC44);

    // Faults: misaligned, out of range, misaligned store.
    set_req(0, 1'b1, 1'b0, 32'h2002, 32'h0, 4'h0);
    tick();
    clear_reqs();
    set_req(1, 1'b1, 1'b0, 32'h2000, 32'h0, 4'h0);
    tick();
    clear_reqs();
    set_req(0, 1'b1, 1'b1, 32'h41, 32'h12345678, 4'hF);
    tick();
    clear_reqs();
    tick();

    // Full store then immediate reload; then an empty store.
    set_req(0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF);
    tick();
    clear_reqs();
    set_req(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    tick();
    clear_reqs();
    set_req(1, 1'b1, 1'b1, 32'h44, 32'hFFFFFFFF, 4'h0);
    tick();
    clear_reqs();
    tick();

    // Randomised traffic over a small window of words.
    for (int n = 0; n < 400; n++) begin
      clear_reqs();
      for (int i = 0; i < 2; i++) begin
        ra = 32'($urandom_range(0, 31)) << 2;
        case ($urandom_range(0, 15))
          0:       ra = ra | 32'($urandom_range(1, 3));
          1:       ra = MSIZE + ra;
          default: ;
        endcase
        case ($urandom_range(0, 3))
          0:       rbe = 4'hF;
          1:       rbe = 4'h0;
          default: rbe = 4'($urandom);
        endcase
        set_req(i, 1'($urandom), 1'($urandom), ra, $urandom, rbe);
      end
      tick();
    end
    clear_reqs();
    tick();
    tick();

    // Reset during RMW_WR drops the write and its response.
    orig = ref_mem[12];
    set_req(0, 1'b1, 1'b1, 32'h30, ~orig, 4'b0011);
    tick();
    clear_reqs();
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst_rmw");
    pend_q.delete();
    busy = 1'b0; wr_pend = 1'b0; prio = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("rst_rmw_word", mem[12], orig);
    set_req(1, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
    tick();
    clear_reqs();
    tick();

    for (int i = 0; i < 32; i++) chk("mem_image", mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
